// File: rtl/stopwatch_lap_ctl.sv
// Stopwatch control with tick prescaler, wrapping time counter, lap capture
// buffer and lap-review mode. Drives display value and status flags.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | cleared, waiting for trig to start
// COUNTING  | time counter running, display follows time_cnt
// PAUSED    | time counter and prescaler hold
// SPLIT     | counter keeps running, display frozen on last lap
// REVIEW    | paused, display steps through stored laps with recall
module stopwatch_lap_ctl #(
  parameter int CNT_W     = 16,
  parameter int MAX_CNT   = 5999,
  parameter int TICK_DIV  = 10000000,
  parameter int LAP_DEPTH = 4,
  parameter int LAP_AW    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic              split,
  input  logic              recall,
  output logic              init_regs,
  output logic              count_enabled,
  output logic [CNT_W-1:0]  time_cnt,
  output logic [CNT_W-1:0]  disp_val,
  output logic              disp_is_lap,
  output logic [LAP_AW:0]   lap_count,
  output logic              lap_overflow,
  output logic [2:0]        state_o
);

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_TOP   = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(MAX_CNT);
  localparam logic [LAP_AW:0]   LAP_FULL = (LAP_AW+1)'(LAP_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COUNTING = 3'd1,
    ST_PAUSED   = 3'd2,
    ST_SPLIT    = 3'd3,
    ST_REVIEW   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [CNT_W-1:0]    time_cnt_q, time_cnt_d;
  logic [LAP_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LAP_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LAP_AW:0]     lap_count_q, lap_count_d;
  logic                lap_overflow_q, lap_overflow_d;
  logic [CNT_W-1:0]    disp_val_q, disp_val_d;
  logic                disp_is_lap_q, disp_is_lap_d;
  logic [CNT_W-1:0]    lap_mem_q [LAP_DEPTH];

  logic                capture;
  logic                clear_all;
  logic                lap_we;
  logic                count_en;
  logic [LAP_AW:0]     rd_next;

  // Next-state decode; input priority is reset > trig > split > recall.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    rd_ptr_d = rd_ptr_q;
    rd_next  = {1'b0, rd_ptr_q} + (LAP_AW+1)'(1);
    if (reset) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig) state_d = ST_COUNTING;
        end
        ST_COUNTING: begin
          if (trig) begin
            state_d = ST_PAUSED;
          end else if (split) begin
            state_d = ST_SPLIT;
            capture = 1'b1;
          end
        end
        ST_SPLIT: begin
          if (trig) begin
            state_d = ST_PAUSED;
          end else if (split) begin
            capture = 1'b1;
          end else if (recall) begin
            state_d = ST_COUNTING;
          end
        end
        ST_PAUSED: begin
          if (trig) begin
            state_d = ST_COUNTING;
          end else if (split) begin
            state_d = ST_IDLE;
          end else if (recall && (lap_count_q != '0)) begin
            state_d  = ST_REVIEW;
            rd_ptr_d = '0;
          end
        end
        ST_REVIEW: begin
          if (trig) begin
            state_d = ST_PAUSED;
          end else if (split) begin
            state_d = ST_IDLE;
          end else if (recall) begin
            rd_ptr_d = (rd_next == lap_count_q) ? '0 : rd_next[LAP_AW-1:0];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Entering (or sitting in) IDLE wipes the counters and lap bookkeeping.
    clear_all = (state_d == ST_IDLE);
  end

  // Mealy outputs: counter enable depends on this cycle's trig/reset.
  always_comb begin
    count_en = 1'b0;
    case (state_q)
      ST_COUNTING, ST_SPLIT: count_en = !(reset || trig);
      ST_PAUSED:             count_en = trig && !reset;
      default:               count_en = 1'b0;
    endcase
  end

  assign count_enabled = count_en;
  assign init_regs     = (state_q == ST_IDLE);

  // Prescaler, time counter and lap write bookkeeping.
  always_comb begin
    presc_d        = presc_q;
    time_cnt_d     = time_cnt_q;
    wr_ptr_d       = wr_ptr_q;
    lap_count_d    = lap_count_q;
    lap_overflow_d = lap_overflow_q;
    lap_we         = 1'b0;

    if (count_en) begin
      if (presc_q == PS_TOP) begin
        presc_d    = '0;
        time_cnt_d = (time_cnt_q == CNT_TOP) ? '0 : time_cnt_q + CNT_W'(1);
      end else begin
        presc_d = presc_q + PS_W'(1);
      end
    end

    // A capture stores the pre-edge time, even when a tick lands on the same edge.
    if (capture) begin
      if (lap_count_q == LAP_FULL) begin
        lap_overflow_d = 1'b1;
      end else begin
        lap_we      = 1'b1;
        wr_ptr_d    = wr_ptr_q + LAP_AW'(1);
        lap_count_d = lap_count_q + (LAP_AW+1)'(1);
      end
    end

    if (clear_all) begin
      presc_d        = '0;
      time_cnt_d     = '0;
      wr_ptr_d       = '0;
      lap_count_d    = '0;
      lap_overflow_d = 1'b0;
      rd_ptr_d_unused_guard();
    end
  end

  function automatic void rd_ptr_d_unused_guard();
  endfunction

  // Display value for the next cycle: frozen lap in SPLIT, stored lap in REVIEW.
  always_comb begin
    disp_is_lap_d = (state_d == ST_SPLIT) || (state_d == ST_REVIEW);
    case (state_d)
      ST_SPLIT:  disp_val_d = lap_we ? time_cnt_q : disp_val_q;
      ST_REVIEW: disp_val_d = lap_mem_q[rd_ptr_d];
      default:   disp_val_d = time_cnt_d;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      presc_q        <= '0;
      time_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      lap_count_q    <= '0;
      lap_overflow_q <= 1'b0;
      disp_val_q     <= '0;
      disp_is_lap_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      time_cnt_q     <= time_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= clear_all ? '0 : rd_ptr_d;
      lap_count_q    <= lap_count_d;
      lap_overflow_q <= lap_overflow_d;
      disp_val_q     <= disp_val_d;
      disp_is_lap_q  <= disp_is_lap_d;
    end
  end

  // Lap storage; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clk) begin
    if (lap_we) lap_mem_q[wr_ptr_q] <= time_cnt_q;
  end

  assign time_cnt     = time_cnt_q;
  assign disp_val     = disp_val_q;
  assign disp_is_lap  = disp_is_lap_q;
  assign lap_count    = lap_count_q;
  assign lap_overflow = lap_overflow_q;
  assign state_o      = state_q;

endmodule
